// File: rtl/ddr_cmd_scheduler.sv
// rtl/ddr_cmd_scheduler.sv - ACT/CAS/data-slot timing scheduler feeding the burst data stage
//
// Purpose: requests are carried in order through three FIFOs (ACT -> CAS -> data slot).
// The scheduler issues one-cycle ACT, CAS and data-phase strobes while it enforces tRRD,
// tRCD, tCCD and the per-direction CAS-to-data delay. At most one ACT or CAS is issued
// per cycle, and CAS has priority over ACT. Every strobe is registered: a decision made
// in cycle t produces a pulse in cycle t+1, and each timestamp is that pulse cycle.
//
// Ports:
//   clock_t, reset_n         clock, synchronous active-low reset
//   init_done                no ACT/CAS is issued while this is low
//   req_valid/req_rw/req_ready  request handshake; rw 2'b01 = READ, 2'b10 = WRITE
//   t_rrd, t_rcd, t_ccd      minimum ACT-ACT, ACT-CAS and CAS-CAS spacing (cycles)
//   rd_delay, wr_delay       CAS-to-data-phase delay per direction (>= 1)
//   act_rdy, cas_rdy, rw_rdy one-cycle strobes; rw_type is the owner's rw on rw_rdy
//   drop_err                 accepted request had an illegal rw
//   busy                     some queue held work in the previous cycle
module ddr_cmd_scheduler #(
   parameter int DEPTH = 4,
   parameter int TW    = 16   // must exceed 8 so that 8-bit spacings fit
) (
   input  logic       clock_t,
   input  logic       reset_n,
   input  logic       init_done,
   input  logic       req_valid,
   input  logic [1:0] req_rw,
   output logic       req_ready,
   input  logic [7:0] t_rrd,
   input  logic [7:0] t_rcd,
   input  logic [7:0] t_ccd,
   input  logic [7:0] rd_delay,
   input  logic [7:0] wr_delay,
   output logic       act_rdy,
   output logic       cas_rdy,
   output logic       rw_rdy,
   output logic [1:0] rw_type,
   output logic       drop_err,
   output logic       busy
);

   localparam logic [1:0] RW_READ  = 2'b01;
   localparam logic [1:0] RW_WRITE = 2'b10;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   // queue storage
   logic [1:0]    act_q_rw   [DEPTH];
   logic [1:0]    cas_q_rw   [DEPTH];
   logic [TW-1:0] cas_q_t    [DEPTH];
   logic [1:0]    slot_q_rw  [DEPTH];
   logic [TW-1:0] slot_q_due [DEPTH];

   logic [AW-1:0] act_wr, act_rd, cas_wr, cas_rd, slot_wr, slot_rd;
   logic [CW-1:0] act_cnt, cas_cnt, slot_cnt, act_cnt_n;

   logic [TW-1:0] cnt, pulse;
   logic [TW-1:0] last_act, last_cas, last_due;
   logic          last_act_v, last_cas_v, last_due_v;

   logic          accept, legal_rw, push_act;
   logic [7:0]    cas_delay;
   logic [TW-1:0] cas_due, due_diff;
   logic          rrd_ok, rcd_ok, ccd_ok, ord_ok;
   logic          do_act, do_cas, do_rw;
   logic          act_stale, cas_stale;

   assign pulse    = cnt + TW'(1);
   assign accept   = req_valid && req_ready;
   assign legal_rw = (req_rw == RW_READ) || (req_rw == RW_WRITE);
   assign push_act = accept && legal_rw;

   // The delay is sampled here, at decision time, and it fixes the slot's due cycle.
   assign cas_delay = (cas_q_rw[cas_rd] == RW_READ) ? rd_delay : wr_delay;
   assign cas_due   = pulse + TW'(cas_delay);
   assign due_diff  = cas_due - last_due;

   // Every spacing is a modular difference, so the free-running counter can wrap.
   assign rrd_ok = !last_act_v || ((pulse - last_act) >= TW'(t_rrd));
   assign rcd_ok = (pulse - cas_q_t[cas_rd]) >= TW'(t_rcd);
   assign ccd_ok = !last_cas_v || ((pulse - last_cas) >= TW'(t_ccd));
   // Dues must strictly increase. Without that, two slots could want the same rw_rdy cycle.
   assign ord_ok = !last_due_v || (!due_diff[TW-1] && (due_diff != '0));

   // An old tracker would wrap back into range after 2^TW cycles. Once its age exceeds any
   // 8-bit spacing it can no longer constrain anything, so it is dropped.
   assign act_stale = (cnt - last_act) > TW'(255);
   assign cas_stale = (cnt - last_cas) > TW'(255);

   assign do_cas = init_done && (cas_cnt != '0) && (slot_cnt != FULL)
                   && rcd_ok && ccd_ok && ord_ok;
   assign do_act = init_done && (act_cnt != '0) && (cas_cnt != FULL)
                   && rrd_ok && !do_cas;
   assign do_rw  = (slot_cnt != '0) && (slot_q_due[slot_rd] == pulse);

   always_comb begin
      act_cnt_n = act_cnt;
      if (push_act && !do_act)
         act_cnt_n = act_cnt + CW'(1);
      else if (!push_act && do_act)
         act_cnt_n = act_cnt - CW'(1);
   end

   always_ff @(posedge clock_t) begin
      if (push_act)
         act_q_rw[act_wr] <= req_rw;
      if (do_act) begin
         cas_q_rw[cas_wr] <= act_q_rw[act_rd];
         cas_q_t[cas_wr]  <= pulse;
      end
      if (do_cas) begin
         slot_q_rw[slot_wr]  <= cas_q_rw[cas_rd];
         slot_q_due[slot_wr] <= cas_due;
      end
   end

   always_ff @(posedge clock_t) begin
      if (!reset_n) begin
         cnt        <= '0;
         act_wr     <= '0;
         act_rd     <= '0;
         act_cnt    <= '0;
         cas_wr     <= '0;
         cas_rd     <= '0;
         cas_cnt    <= '0;
         slot_wr    <= '0;
         slot_rd    <= '0;
         slot_cnt   <= '0;
         last_act   <= '0;
         last_cas   <= '0;
         last_due   <= '0;
         last_act_v <= 1'b0;
         last_cas_v <= 1'b0;
         last_due_v <= 1'b0;
         act_rdy    <= 1'b0;
         cas_rdy    <= 1'b0;
         rw_rdy     <= 1'b0;
         rw_type    <= 2'b00;
         drop_err   <= 1'b0;
         busy       <= 1'b0;
         req_ready  <= 1'b1;
      end else begin
         cnt <= pulse;

         if (push_act)
            act_wr <= inc(act_wr);
         if (do_act)
            act_rd <= inc(act_rd);
         act_cnt <= act_cnt_n;

         // ACT and CAS are never both issued, so the CAS queue does not push and pop together.
         if (do_act) begin
            cas_wr  <= inc(cas_wr);
            cas_cnt <= cas_cnt + CW'(1);
         end else if (do_cas) begin
            cas_rd  <= inc(cas_rd);
            cas_cnt <= cas_cnt - CW'(1);
         end

         if (do_cas)
            slot_wr <= inc(slot_wr);
         if (do_rw)
            slot_rd <= inc(slot_rd);
         if (do_cas && !do_rw)
            slot_cnt <= slot_cnt + CW'(1);
         else if (!do_cas && do_rw)
            slot_cnt <= slot_cnt - CW'(1);

         if (do_act) begin
            last_act   <= pulse;
            last_act_v <= 1'b1;
         end else if (act_stale) begin
            last_act_v <= 1'b0;
         end

         if (do_cas) begin
            last_cas   <= pulse;
            last_cas_v <= 1'b1;
         end else if (cas_stale) begin
            last_cas_v <= 1'b0;
         end

         // Once the counter reaches the last due, any later due is automatically later.
         if (do_cas) begin
            last_due   <= cas_due;
            last_due_v <= 1'b1;
         end else if (cnt == last_due) begin
            last_due_v <= 1'b0;
         end

         act_rdy  <= do_act;
         cas_rdy  <= do_cas;
         rw_rdy   <= do_rw;
         rw_type  <= do_rw ? slot_q_rw[slot_rd] : 2'b00;
         drop_err <= accept && !legal_rw;
         busy     <= (act_cnt != '0) || (cas_cnt != '0) || (slot_cnt != '0);
         // Uses the count after this cycle's push/pop. An ACT pop never makes room for a
         // request that arrives in the same cycle.
         req_ready <= (act_cnt_n != FULL);
      end
   end

endmodule
